cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus among N execution units. Each unit offers
//  a finished result {tag, wdata} with a req/rdy handshake. The block grants one
//  unit per cycle in round-robin order and broadcasts the winner one cycle later
//  on the registered CDB master port (wr/tag/wdata). Reservation stations, the
//  register file and the ROB snoop that port.
// PARAMETERS
//  N_REQ   4    number of execution-unit requesters (>=2)
//  TAG_W   4    ROB tag width, bits
// PORTS
//  clk         in   1          clock
//  rst         in   1          asynchronous reset, active-high
//  exu_req     in   N_REQ      per-unit result valid
//  exu_rdy     out  N_REQ      per-unit grant (combinational, one-hot or zero)
//  exu_tag     in   N_REQ*TAG_W  unit i tag at [i*TAG_W +: TAG_W]
//  exu_wdata   in   N_REQ*32   unit i result at [i*32 +: 32]
//  cdb_wr      out  1          broadcast valid (registered)
//  cdb_tag     out  TAG_W      broadcast tag (registered)
//  cdb_wdata   out  32         broadcast data (registered)
// BEHAVIOUR
//  - Reset (async, rst=1): cdb_wr=0, cdb_tag=0, cdb_wdata=0, ptr=0. exu_rdy is
//    forced to 0 while rst=1.
//  - Priority pointer ptr (clog2(N_REQ) bits). Search order is ptr, ptr+1, ...,
//    wrapping mod N_REQ. The first i with exu_req[i]=1 gets exu_rdy[i]=1. All
//    other rdy bits are 0. No req gives rdy=0.
//  - Transfer occurs on exu_req[i] & exu_rdy[i]. At most one transfer per cycle.
//  - Requester rule: once req is raised, req/tag/wdata stay stable until the
//    transfer. The arbiter does not check this. A requester may drop req only
//    after its transfer cycle.
//  - Latency: a transfer in cycle t gives cdb_wr=1 with that tag/wdata in cycle
//    t+1, for exactly one cycle. No transfer in t gives cdb_wr=0 in t+1.
//    tag/wdata hold their last value when wr=0.
//  - Pointer update on transfer to i: ptr <= (i==N_REQ-1) ? 0 : i+1 (wrap).
//    No transfer leaves ptr unchanged.
//  - Fairness: a continuously requesting unit is granted within N_REQ cycles.
//  - Back-to-back: one unit may transfer in consecutive cycles if it is the only
//    requester. The CDB sustains one result per cycle with no bubbles.
//  - Simultaneous: all N_REQ requesting gives grant order ptr, ptr+1, ... with
//    one per cycle.
//  - Reset mid-operation: any pending CDB broadcast is dropped (cdb_wr=0
//    immediately). Requesters must re-present after reset.
//  - The CDB has no backpressure. The arbiter never stalls the output.
// STRUCTURE
//  - Shared package cdb_pkg: cdb_pkt_t {logic [TAG_W-1:0] tag; logic [31:0]
//    wdata;}, default TAG_W constant. The block uses it for the output register.
//  - Sub-module rr_arb #(N): req vector + ptr in, one-hot gnt + gnt_idx out,
//    purely combinational. The parent owns the ptr and output registers and the
//    data mux (one-hot AND-OR over exu_tag/exu_wdata).
// TESTING (N_REQ=4, TAG_W=4)
//  - Reset: hold rst with req=4'b1111 -> rdy=0, cdb_wr=0. Release -> rdy=0001
//    in the same cycle, cdb_wr=1 with tag of unit 0 next cycle.
//  - Single req: unit2 req, tag=5, wdata=32'hDEAD_BEEF -> rdy=0100, next cycle
//    wr=1/tag=5/wdata=DEADBEEF, ptr=3.
//  - All four req held -> grants 0,1,2,3,0 in consecutive cycles. cdb_wr is
//    high every cycle with matching tags.
//  - Wrap: ptr=3, req=1001 -> unit3 granted, then unit0. ptr goes to 0, then 1.
//  - Async reset mid-stream: assert rst between edges while cdb_wr=1 ->
//    wr/tag/wdata go to 0 before the next edge, ptr=0.
//  - Random stress: random req/hold pattern for 10k cycles. A scoreboard checks
//    each accepted {tag, wdata} appears exactly once, in order, one cycle after
//    its grant, and no unit waits more than 4 cycles.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions: broadcast packet layout and round-robin helpers.
package cdb_pkg;

   localparam int unsigned CDB_TAG_W  = 4;
   localparam int unsigned CDB_DATA_W = 32;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] wdata;
   } cdb_pkt_t;

   // Next round-robin position after idx, wrapping at n.
   function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set req bit at or after ptr wins.
module rr_arb #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] idx_c;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      idx_c     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx_c = IDX_W'((32'(ptr_i) + k) % N);
         if (!any_o && req_i[idx_c]) begin
            any_o        = 1'b1;
            gnt_idx_o    = idx_c;
            gnt_o[idx_c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among execution units, winner
// broadcast on the registered CDB port one cycle after its transfer.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned TAG_W = CDB_TAG_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         exu_req,
   output logic [N_REQ-1:0]         exu_rdy,
   input  logic [N_REQ*TAG_W-1:0]   exu_tag,
   input  logic [N_REQ*32-1:0]      exu_wdata,
   output logic                     cdb_wr,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [31:0]              cdb_wdata
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             wr_q, wr_d;
   cdb_pkt_t         pkt_q, pkt_d;

   logic [N_REQ-1:0] gnt;
   logic [PTR_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             xfer_c;
   logic [TAG_W-1:0] tag_mux;
   logic [31:0]      wdata_mux;

   rr_arb #(
      .N     (N_REQ),
      .IDX_W (PTR_W)
   ) u_rr_arb (
      .req_i     (exu_req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   // Grants are suppressed while reset is held so nothing transfers into a dead bus.
   assign exu_rdy = rst ? '0 : gnt;
   assign xfer_c  = gnt_any & ~rst;

   // One-hot AND-OR select of the winning unit's result.
   always_comb begin
      tag_mux   = '0;
      wdata_mux = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         tag_mux   = tag_mux   | (exu_tag[i*TAG_W +: TAG_W] & {TAG_W{gnt[i]}});
         wdata_mux = wdata_mux | (exu_wdata[i*32 +: 32]     & {32{gnt[i]}});
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      wr_d  = 1'b0;
      pkt_d = pkt_q;
      if (xfer_c) begin
         ptr_d       = PTR_W'(rr_wrap_inc(32'(gnt_idx), N_REQ));
         wr_d        = 1'b1;
         pkt_d.tag   = CDB_TAG_W'(tag_mux);
         pkt_d.wdata = wdata_mux;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         wr_q  <= 1'b0;
         pkt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         wr_q  <= wr_d;
         pkt_q <= pkt_d;
      end
   end

   assign cdb_wr    = wr_q;
   assign cdb_tag   = TAG_W'(pkt_q.tag);
   assign cdb_wdata = pkt_q.wdata;

endmodule
